crypt_result_collector: RTL

- Consumer at the output end of the DES crypt round pipeline: takes the final L/R halves of each candidate and compares them against a programmed 64-bit target hash.
- On a match, buffers the candidate tag in a small FIFO for the host-side reader, using a valid/ready handshake.
- The pipeline is free-running, so this block never back-pressures it. Matches that arrive with the FIFO full are dropped and flagged.

---
 rtl/crypt_result_collector.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/crypt_result_collector.sv
// ---------------------------------------------------------------------------
// crypt_result_collector
//
// Purpose:
//   This block sits at the output end of the DES crypt round pipeline. It
//   compares the final L/R halves of every candidate against a programmed
//   64-bit target hash. The tag of each matching candidate goes into a small
//   FIFO, and a host-side reader drains that FIFO with a valid/ready
//   handshake. The pipeline runs freely and is never stalled. If a match
//   arrives while the FIFO is full, it is dropped and a sticky flag is raised.
//
// Ports:
//   CLK          clock, all state changes on the rising edge
//   RST_N        asynchronous active-low reset
//   L_in, R_in   final left/right halves from the last crypt round stage
//   in_valid     L_in/R_in/tag_in carry a real candidate this cycle
//   tag_in       candidate identifier (TAG_W bits)
//   target_we    load target_L/target_R at the end of this cycle
//   target_L/R   target hash halves
//   out_valid    FIFO non-empty, out_tag is meaningful
//   out_ready    reader accepts the head entry
//   out_tag      tag at the FIFO head
//   overflow     sticky, a match was dropped because the FIFO was full
//   clr_ovf      clears overflow (a simultaneous drop takes priority)
//   match_count  saturating count of all matches, including dropped ones
// ---------------------------------------------------------------------------
module crypt_result_collector #(
    parameter int TAG_W = 32,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [31:0]      L_in,
    input  logic [31:0]      R_in,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             target_we,
    input  logic [31:0]      target_L,
    input  logic [31:0]      target_R,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic             overflow,
    input  logic             clr_ovf,
    output logic [CNT_W-1:0] match_count
);

    localparam int               AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]      FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [31:0]      r_tgtL;
    logic [31:0]      r_tgtR;
    logic             r_eqL;
    logic             r_eqR;
    logic             r_v1;
    logic [TAG_W-1:0] r_tag1;
    logic [TAG_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_count;
    logic             r_ovf;
    logic [CNT_W-1:0] r_matchCnt;

    logic w_hit;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // Target hash registers. Stage 1 samples these before the edge, so a new
    // target only applies to candidates that arrive after the load.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_tgtL <= '0;
            r_tgtR <= '0;
        end else if (target_we) begin
            r_tgtL <= target_L;
            r_tgtR <= target_R;
        end
    end

    // Stage 1 registers the two half-compares separately. This keeps the
    // 64-bit compare off the FIFO control path. Once a result is captured it
    // is not recomputed if the target changes later.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_eqL  <= 1'b0;
            r_eqR  <= 1'b0;
            r_v1   <= 1'b0;
            r_tag1 <= '0;
        end else begin
            r_eqL  <= (L_in == r_tgtL);
            r_eqR  <= (R_in == r_tgtR);
            r_v1   <= in_valid;
            r_tag1 <= tag_in;
        end
    end

    // FIFO control. A pop in the same cycle frees the head slot, so a full
    // FIFO can still take a push. A drop happens only when the FIFO is full
    // and the reader is not taking an entry.
    always_comb begin
        w_hit  = r_v1 & r_eqL & r_eqR;
        w_full = (r_count == FULL_CNT);
        w_pop  = out_valid & out_ready;
        w_push = w_hit & (!w_full | w_pop);
        w_drop = w_hit & w_full & !w_pop;
    end

    // Pointer and occupancy bookkeeping. Pointers wrap naturally because
    // DEPTH is a power of two.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Tag storage. All entries are cleared on reset, so out_tag reads zero
    // until the first push.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr] <= r_tag1;
        end
    end

    // Sticky overflow flag. When a drop and a clear happen in the same
    // cycle, the drop wins so the event is not lost.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    // Saturating match counter. It counts every hit, pushed or dropped.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_matchCnt <= '0;
        end else if (w_hit && (r_matchCnt != CNT_MAX)) begin
            r_matchCnt <= r_matchCnt + 1'b1;
        end
    end

    assign out_valid   = (r_count != '0);
    assign out_tag     = r_mem[r_rd];
    assign overflow    = r_ovf;
    assign match_count = r_matchCnt;

endmodule
